// File: rtl/audio_recorder.sv
// Single-clock sample recorder/looper: captures strobed samples into on-chip RAM
// while record_in is high, then loops the clip back out one sample per strobe.
module audio_recorder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16384
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             record_in,
    input  logic             audio_valid_in,
    input  logic [WIDTH-1:0] audio_in,
    input  logic             finish,
    output logic [WIDTH-1:0] single_out,
    output logic [31:0]      recording_length
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

    state_t           state_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_d;
    logic [31:0]      len_q;
    logic [WIDTH-1:0] out_q;
    logic             vld_p1_q;
    logic [WIDTH-1:0] rd_p1_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full;
    logic             ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_addr;

    // One shared address port: writes only happen with record_in high, reads only in PLAY without it.
    always_comb begin
        full     = (len_q == 32'(DEPTH));
        rptr_d   = (32'(rptr_q) == len_q - 32'd1) ? '0 : rptr_q + PTR_ONE;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = rptr_q;
        if (record_in) begin
            if (state_q == RECORD) begin
                ram_addr = wptr_q;
                ram_we   = audio_valid_in && !full;
            end else begin
                ram_addr = '0;
                ram_we   = audio_valid_in;
            end
        end else if (state_q == PLAY && !finish) begin
            ram_re = audio_valid_in;
        end
    end

    // Stage p0 -> p1: synchronous RAM write and registered read
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            mem_q[ram_addr] <= audio_in;
        end
        if (ram_re) begin
            rd_p1_q <= mem_q[ram_addr];
        end
    end

    // Stage p1 -> output: FSM, counters and playback register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            len_q    <= '0;
            out_q    <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (record_in) begin
                        state_q <= RECORD;
                        wptr_q  <= audio_valid_in ? PTR_ONE : '0;
                        len_q   <= 32'(audio_valid_in);
                        out_q   <= '0;
                    end
                end
                RECORD: begin
                    if (record_in) begin
                        if (audio_valid_in && !full) begin
                            wptr_q <= wptr_q + PTR_ONE;
                            len_q  <= len_q + 32'd1;
                        end
                    end else begin
                        state_q <= (len_q != 32'd0) ? PLAY : IDLE;
                        rptr_q  <= '0;
                        out_q   <= '0;
                    end
                end
                PLAY: begin
                    if (record_in) begin
                        state_q <= RECORD;
                        wptr_q  <= audio_valid_in ? PTR_ONE : '0;
                        len_q   <= 32'(audio_valid_in);
                        out_q   <= '0;
                    end else if (finish) begin
                        state_q <= IDLE;
                        out_q   <= '0;
                    end else begin
                        if (vld_p1_q) begin
                            out_q <= rd_p1_q;
                        end
                        if (audio_valid_in) begin
                            rptr_q <= rptr_d;
                        end
                        vld_p1_q <= audio_valid_in;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= '0;
                end
            endcase
        end
    end

    assign single_out       = out_q;
    assign recording_length = len_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: two instances (large and 16-deep) share stimulus,
// each checked every cycle against a behavioural model with a readout scoreboard.
module tb_audio_recorder;

    localparam int DA = 16384;
    localparam int DB = 16;
    localparam int S_IDLE = 0;
    localparam int S_REC  = 1;
    localparam int S_PLAY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rec;
    logic        vin;
    logic        fin;
    logic [7:0]  ain;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [31:0] len_a;
    logic [31:0] len_b;

    audio_recorder #(.WIDTH(8), .DEPTH(DA)) u_a (
        .clk_in(clk), .rst_in(rst_n), .record_in(rec), .audio_valid_in(vin),
        .audio_in(ain), .finish(fin), .single_out(out_a), .recording_length(len_a)
    );

    audio_recorder #(.WIDTH(8), .DEPTH(DB)) u_b (
        .clk_in(clk), .rst_in(rst_n), .record_in(rec), .audio_valid_in(vin),
        .audio_in(ain), .finish(fin), .single_out(out_b), .recording_length(len_b)
    );

    int checks = 0;
    int errors = 0;

    int          st   [2];
    int unsigned mlen [2];
    int unsigned rp   [2];
    logic [7:0]  mout [2];
    logic [7:0]  mem_a [DA];
    logic [7:0]  mem_b [DB];
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            st[d]   = S_IDLE;
            mlen[d] = 0;
            rp[d]   = 0;
            mout[d] = 8'd0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic clear_q(input int d);
        if (d == 0) qa.delete();
        else        qb.delete();
    endtask

    task automatic cap(input int d);
        int unsigned depth;
        depth = (d == 0) ? DA : DB;
        if (vin && mlen[d] < depth) begin
            if (d == 0) mem_a[mlen[d]] = ain;
            else        mem_b[mlen[d]] = ain;
            mlen[d]++;
        end
    endtask

    task automatic start_rec(input int d);
        st[d]   = S_REC;
        mlen[d] = 0;
        mout[d] = 8'd0;
        clear_q(d);
        cap(d);
    endtask

    task automatic model_edge(input int d);
        logic [7:0] v;
        case (st[d])
            S_IDLE: if (rec) start_rec(d);
            S_REC: begin
                if (rec) cap(d);
                else begin
                    st[d] = (mlen[d] > 0) ? S_PLAY : S_IDLE;
                    rp[d] = 0;
                end
            end
            S_PLAY: begin
                if (rec) start_rec(d);
                else if (fin) begin
                    st[d]   = S_IDLE;
                    mout[d] = 8'd0;
                    clear_q(d);
                end else begin
                    if (d == 0) begin
                        if (qa.size() > 0) mout[d] = qa.pop_front();
                    end else begin
                        if (qb.size() > 0) mout[d] = qb.pop_front();
                    end
                    if (vin) begin
                        if (d == 0) begin
                            v = mem_a[rp[d]];
                            qa.push_back(v);
                        end else begin
                            v = mem_b[rp[d]];
                            qb.push_back(v);
                        end
                        rp[d] = (rp[d] == mlen[d] - 1) ? 0 : rp[d] + 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("out_a", 32'(out_a), 32'(mout[0]));
        chk("len_a", len_a, mlen[0]);
        chk("out_b", 32'(out_b), 32'(mout[1]));
        chk("len_b", len_b, mlen[1]);
    endtask

    task automatic strobe(input int gap);
        vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic async_reset_check(input string tag);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_out_a"}, 32'(out_a), 32'd0);
        chk({tag, "_len_a"}, len_a, 32'd0);
        chk({tag, "_out_b"}, 32'(out_b), 32'd0);
        chk({tag, "_len_b"}, len_b, 32'd0);
        rec = 1'b0;
        vin = 1'b0;
        fin = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rec   = 1'b0;
        vin   = 1'b0;
        fin   = 1'b0;
        ain   = 8'd0;
        model_reset();
        #12;
        chk("reset_out_a", 32'(out_a), 32'd0);
        chk("reset_len_a", len_a, 32'd0);
        chk("reset_out_b", 32'(out_b), 32'd0);
        chk("reset_len_b", len_b, 32'd0);
        rst_n = 1'b1;

        // Basic record of 10000 back-to-back samples
        rec = 1'b1;
        vin = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            ain = 8'(i);
            tick();
        end
        rec = 1'b0;
        vin = 1'b0;
        tick();
        chk("rec_len_a", len_a, 32'd10000);
        chk("rec_len_b", len_b, 32'd16);

        // Playback: sparse, then consecutive, then sparse across the loop point
        for (int n = 0; n < 300; n++) strobe(6);
        chk("loop_a", 32'(out_a), 32'd43);
        vin = 1'b1;
        for (int n = 300; n < 9990; n++) tick();
        for (int n = 9990; n < 10001; n++) strobe(6);
        chk("wrap_a", 32'(out_a), 32'd0);

        // record_in wins over finish, then re-record 5 samples of 9
        rec = 1'b1;
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("prio_len_a", len_a, 32'd0);
        vin = 1'b1;
        ain = 8'd9;
        repeat (5) tick();
        vin = 1'b0;
        rec = 1'b0;
        tick();
        chk("rerec_len_a", len_a, 32'd5);
        chk("rerec_len_b", len_b, 32'd5);
        for (int n = 0; n < 12; n++) strobe(2);
        chk("rerec_out_a", 32'(out_a), 32'd9);

        // finish returns to IDLE and strobes are ignored
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("fin_out_a", 32'(out_a), 32'd0);
        for (int n = 0; n < 3; n++) strobe(1);

        // Saturation: 20 samples into the 16-deep instance
        rec = 1'b1;
        vin = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            ain = 8'(i);
            tick();
        end
        vin = 1'b0;
        rec = 1'b0;
        tick();
        chk("sat_len_b", len_b, 32'd16);
        chk("sat_len_a", len_a, 32'd20);
        for (int n = 0; n < 18; n++) strobe(1);
        chk("sat_out_b", 32'(out_b), 32'd2);
        chk("sat_out_a", 32'(out_a), 32'd18);

        // Asynchronous reset mid-PLAY
        async_reset_check("rst_play");
        for (int n = 0; n < 3; n++) strobe(1);

        // Asynchronous reset mid-RECORD
        rec = 1'b1;
        vin = 1'b1;
        ain = 8'd77;
        repeat (5) tick();
        async_reset_check("rst_rec");
        for (int n = 0; n < 3; n++) strobe(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
Single-clock 8-bit audio sample recorder/looper. While record_in is high it captures valid input samples into an on-chip sample RAM and counts them. When record_in falls it loops the captured clip back out, one sample per audio_valid_in strobe. Sits between the audio sample source (e.g. mic/ADC decimator) and the playback path (PWM/DAC).

Parameters:
WIDTH, 8, sample width in bits; ports below assume 8.
DEPTH, 16384, RAM capacity in samples; power of two, at least 2.

Ports:
clk_in  input  1  system clock; all logic rising-edge.
rst_in  input  1  asynchronous active-low reset.
record_in  input  1  level; high = record, low = play back the last clip.
audio_valid_in  input  1  sample strobe; write qualifier in RECORD, read advance in PLAY.
audio_in  input  8  sample to record; sampled when audio_valid_in=1 in RECORD.
finish  input  1  stop playback; return to IDLE.
single_out  output  8  current playback sample.
recording_length  output  32  number of samples in the stored clip.

Behaviour:
- Reset (rst_in=0, async): state=IDLE, single_out=0, recording_length=0, write pointer=0, read pointer=0. RAM contents are not cleared; they are unused while recording_length=0.
- States and transitions, evaluated each edge:
  - IDLE -> RECORD when record_in=1.
  - RECORD -> PLAY when record_in=0 and recording_length>0.
  - RECORD -> IDLE when record_in=0 and recording_length=0.
  - PLAY -> RECORD when record_in=1.
  - PLAY -> IDLE when finish=1 and record_in=0.
  - record_in has priority over finish. finish has no effect in IDLE or RECORD.
- Entering RECORD from any state: write pointer=0 and recording_length=0 on that edge. A new recording always discards the old clip.
- RECORD sample capture:
  - Each edge with audio_valid_in=1: RAM[wptr] <= audio_in, wptr++, recording_length++.
  - This applies on the entry edge itself, so a sample presented on the edge where record_in is first seen high is captured as sample 0.
  - Back-to-back strobes every cycle are supported.
- Full: when recording_length = DEPTH, further strobes are ignored. Length saturates at DEPTH and no RAM address wraps.
- Entering PLAY: rptr=0. single_out holds its value until the first strobe.
- PLAY readout:
  - Edge k with audio_valid_in=1: RAM read of rptr is issued.
  - rptr <= (rptr = recording_length-1) ? 0 : rptr+1, so the clip loops indefinitely.
  - single_out takes RAM[old rptr] at edge k+1 (synchronous RAM read, 1-cycle latency) and holds until the next update.
  - Strobes on consecutive cycles yield consecutive samples on consecutive cycles.
- single_out in IDLE and RECORD: 0; forced to 0 on the edge entering either state.
- recording_length is stable in PLAY and IDLE. It changes only in RECORD or on reset.
- audio_valid_in in IDLE: ignored.
- RAM: single port, synchronous write, 1-cycle registered read; inferable as block RAM.
- Implementation target: roughly 120-250 lines (FSM, pointer/length counters, RAM, output register).

Test Plan:
- Basic record:
  - Stimulus: reset; record_in=1; 10000 consecutive cycles with audio_valid_in=1 and audio_in=i[7:0]; record_in=0.
  - Response: recording_length=10000; state PLAY.
- Playback loop:
  - Stimulus: after the basic record, strobe audio_valid_in one cycle in every 7.
  - Response: single_out = 0,1,2,...,255,0,1,..., i.e. (n mod 10000)[7:0]. Each value appears one cycle after its strobe. Strobe 10001 returns sample 0 (value 0).
- Full saturation:
  - Stimulus: DEPTH=16; record 20 samples with values 1..20.
  - Response: recording_length=16; playback sequence 1..16 then wraps to 1.
- Finish and priority:
  - Stimulus: finish=1 during PLAY.
  - Response: next edge single_out=0, IDLE; subsequent strobes leave single_out=0.
  - Stimulus: record_in=1 and finish=1 together.
  - Response: enters RECORD; recording_length=0.
- Re-record:
  - Stimulus: during PLAY raise record_in and record 5 samples (values 9).
  - Response: recording_length=5; playback loops 9,9,9,9,9.
- Async reset mid-operation:
  - Stimulus: pull rst_in low mid-RECORD and mid-PLAY, with no clock edge.
  - Response: single_out=0 and recording_length=0 immediately. After release with record_in=0, state stays IDLE and strobes give single_out=0.
